// File: rtl/ps2_digit_rx.sv
// PS/2 keyboard receiver with a two-digit, calculator-style digit decoder.
// The PS/2 lines are synchronised, 11-bit frames are deframed and checked,
// and set-2 digit make codes shift into two BCD digits from the right.
//
// Handshake: o_byte_valid, o_key_valid and o_err are single-cycle strobes
// with no ready. Consumers must take o_byte on the cycle o_byte_valid is high,
// and o_num1/o_num2 on the cycle o_key_valid is high. No back-pressure exists.
module ps2_digit_rx #(
  parameter int TIMEOUT_CYC = 50000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [3:0] o_num1,
  output logic [3:0] o_num2,
  output logic       o_key_valid,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_err,
  output logic [1:0] o_state
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  logic                   fe;
  logic                   ps2_d;
  logic [3:0]             bit_cnt;
  logic [7:0]             shift_reg;
  logic                   par_bit;
  logic                   stop_bit;
  logic [TW-1:0]          tmo_cnt;
  logic                   brk;
  logic                   ext;
  logic                   dig_hit;
  logic [3:0]             dig_val;

  // Synchronise both PS/2 lines; reset to the idle-high line level so that
  // leaving reset never looks like a falling edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], i_ps2_data};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign fe      = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign ps2_d   = data_sync[SYNC_STAGES-1];
  assign o_state = state;

  // Frame deframer: start bit, 8 data bits LSB first, odd parity, stop bit,
  // with an inactivity timeout that abandons a partial frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      par_bit      <= 1'b0;
      stop_bit     <= 1'b0;
      tmo_cnt      <= '0;
      o_byte       <= 8'h00;
      o_byte_valid <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      o_byte_valid <= 1'b0;
      o_err        <= 1'b0;
      case (state)
        IDLE: begin
          // A falling edge with data high is line noise, not a start bit.
          if (fe && !ps2_d) begin
            state   <= RECV;
            bit_cnt <= 4'd1;
            tmo_cnt <= '0;
          end
        end
        RECV: begin
          if (fe) begin
            tmo_cnt <= '0;
            if (bit_cnt <= 4'd8) shift_reg <= {ps2_d, shift_reg[7:1]};
            if (bit_cnt == 4'd9) par_bit <= ps2_d;
            if (bit_cnt == 4'd10) begin
              stop_bit <= ps2_d;
              state    <= CHECK;
            end
            bit_cnt <= bit_cnt + 4'd1;
          end else if (tmo_cnt == TMO_LAST) begin
            o_err <= 1'b1;
            state <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        CHECK: begin
          if ((^{shift_reg, par_bit}) && stop_bit) begin
            o_byte       <= shift_reg;
            o_byte_valid <= 1'b1;
          end else begin
            o_err <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Map scan-code set 2 digit make codes (top row and keypad) to BCD.
  always_comb begin
    dig_hit = 1'b1;
    dig_val = 4'd0;
    case (o_byte)
      8'h45, 8'h70: dig_val = 4'd0;
      8'h16, 8'h69: dig_val = 4'd1;
      8'h1E, 8'h72: dig_val = 4'd2;
      8'h26, 8'h7A: dig_val = 4'd3;
      8'h25, 8'h6B: dig_val = 4'd4;
      8'h2E, 8'h73: dig_val = 4'd5;
      8'h36, 8'h74: dig_val = 4'd6;
      8'h3D, 8'h6C: dig_val = 4'd7;
      8'h3E, 8'h75: dig_val = 4'd8;
      8'h46, 8'h7D: dig_val = 4'd9;
      default:      dig_hit = 1'b0;
    endcase
  end

  // Digit decoder: consumes each received byte one cycle after its strobe.
  // Break (F0) and extended (E0) prefixes suppress the action of the next
  // ordinary byte, so key releases and extended keys never shift digits.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_num1      <= 4'd0;
      o_num2      <= 4'd0;
      o_key_valid <= 1'b0;
      brk         <= 1'b0;
      ext         <= 1'b0;
    end else begin
      o_key_valid <= 1'b0;
      if (o_byte_valid) begin
        if (o_byte == 8'hF0) begin
          brk <= 1'b1;
        end else if (o_byte == 8'hE0) begin
          ext <= 1'b1;
        end else begin
          if (!brk && !ext) begin
            if (dig_hit) begin
              o_num1      <= o_num2;
              o_num2      <= dig_val;
              o_key_valid <= 1'b1;
            end else if (o_byte == 8'h76) begin
              o_num1      <= 4'd0;
              o_num2      <= 4'd0;
              o_key_valid <= 1'b1;
            end
          end
          brk <= 1'b0;
          ext <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_digit_rx.sv
// Bench for ps2_digit_rx: drives PS/2 frames on the raw lines, models the
// display as a two-digit decimal number, and checks strobes in a monitor.
module tb_ps2_digit_rx;

  localparam int TMO     = 200;
  localparam int HALF_NS = 100;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [3:0] num1, num2;
  logic       key_valid, byte_valid, err;
  logic [7:0] rx_byte;
  logic [1:0] state;

  always #5 clk = ~clk;

  ps2_digit_rx #(.TIMEOUT_CYC(TMO), .SYNC_STAGES(2)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_ps2_clk   (ps2_clk),
    .i_ps2_data  (ps2_data),
    .o_num1      (num1),
    .o_num2      (num2),
    .o_key_valid (key_valid),
    .o_byte      (rx_byte),
    .o_byte_valid(byte_valid),
    .o_err       (err),
    .o_state     (state)
  );

  // ---------------- scoreboard state ----------------
  logic [7:0] byte_q[$];
  logic [7:0] exp_q[$];   // expected {tens, ones} per key strobe
  int         err_pend = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  // reference model: displayed value as a plain decimal number 0..99
  int num_model = 0;
  bit m_brk = 1'b0;
  bit m_ext = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int digit_of(input logic [7:0] b);
    case (b)
      8'h45, 8'h70: return 0;
      8'h16, 8'h69: return 1;
      8'h1E, 8'h72: return 2;
      8'h26, 8'h7A: return 3;
      8'h25, 8'h6B: return 4;
      8'h2E, 8'h73: return 5;
      8'h36, 8'h74: return 6;
      8'h3D, 8'h6C: return 7;
      8'h3E, 8'h75: return 8;
      8'h46, 8'h7D: return 9;
      default:      return -1;
    endcase
  endfunction

  task automatic model_good(input logic [7:0] b);
    int d;
    byte_q.push_back(b);
    if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'hE0) m_ext = 1'b1;
    else begin
      if (!m_brk && !m_ext) begin
        d = digit_of(b);
        if (d >= 0) begin
          num_model = (num_model % 10) * 10 + d;
          exp_q.push_back({4'(num_model / 10), 4'(num_model % 10)});
        end else if (b == 8'h76) begin
          num_model = 0;
          exp_q.push_back(8'h00);
        end
      end
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
  endtask

  // ---------------- driver tasks ----------------
  // Send one frame. abort_bit >= 0 asserts reset just before that bit and
  // returns with reset still held.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int abort_bit);
    logic [10:0] f;
    logic        p;
    p = bad_par ? ^b : ~^b;
    f = {1'b1, p, b, 1'b0};
    if (abort_bit < 0) begin
      if (bad_par) err_pend++;
      else model_good(b);
    end
    for (int i = 0; i < 11; i++) begin
      if (i == abort_bit) begin
        rst_n     = 1'b0;
        ps2_data  = 1'b1;
        num_model = 0;
        m_brk     = 1'b0;
        m_ext     = 1'b0;
        #50;
        break;
      end
      ps2_data = f[i];
      #(HALF_NS);
      ps2_clk = 1'b0;
      #(HALF_NS);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    #(HALF_NS * 4);
  endtask

  // Send only the first n bits of a frame, then leave the lines idle.
  task automatic send_partial(input logic [7:0] b, input int n);
    logic [10:0] f;
    f = {1'b1, ~^b, b, 1'b0};
    err_pend++;
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      #(HALF_NS);
      ps2_clk = 1'b0;
      #(HALF_NS);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic drained(input string tag);
    chk({tag, "_byte_q_empty"}, byte_q.size(), 0);
    chk({tag, "_key_q_empty"}, exp_q.size(), 0);
    chk({tag, "_err_pending"}, err_pend, 0);
  endtask

  // ---------------- monitor ----------------
  logic [7:0] exp_b, exp_k;
  always @(negedge clk) begin
    if (rst_n) begin
      if (byte_valid || err) chk("byte_err_exclusive", byte_valid & err, 1'b0);
      if (byte_valid) begin
        if (byte_q.size() == 0) chk("unexpected_byte_valid", rx_byte, 32'hFFFF);
        else begin
          exp_b = byte_q.pop_front();
          chk("o_byte", rx_byte, exp_b);
        end
      end
      if (key_valid) begin
        if (exp_q.size() == 0) chk("unexpected_key_valid", {num1, num2}, 32'hFFFF);
        else begin
          exp_k = exp_q.pop_front();
          chk("digits", {num1, num2}, exp_k);
        end
      end
      if (err) begin
        chk("err_expected", err_pend > 0, 1'b1);
        if (err_pend > 0) err_pend--;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------- stimulus ----------------
  logic [7:0] top_row[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] keypad[10]  = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};

  initial begin
    logic [7:0] b;
    int         r;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_num1", num1, 4'd0);
    chk("rst_num2", num2, 4'd0);
    chk("rst_byte", rx_byte, 8'h00);
    chk("rst_pulses", {key_valid, byte_valid, err}, 3'b000);
    chk("rst_state", state, 2'd0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // single digit 5
    send_frame(8'h2E, 1'b0, -1);
    drained("first");
    chk("after_2E", {num1, num2}, 8'h05);

    // 1, 2, 9 shift in from the right
    send_frame(8'h16, 1'b0, -1);
    send_frame(8'h1E, 1'b0, -1);
    chk("after_12", {num1, num2}, 8'h12);
    send_frame(8'h7D, 1'b0, -1);
    chk("after_29", {num1, num2}, 8'h29);
    drained("shift");

    // break / extended prefixes suppress the following code
    send_frame(8'h16, 1'b0, -1);
    send_frame(8'hF0, 1'b0, -1);
    send_frame(8'h16, 1'b0, -1);
    send_frame(8'hE0, 1'b0, -1);
    send_frame(8'h70, 1'b0, -1);
    send_frame(8'hE0, 1'b0, -1);
    send_frame(8'hF0, 1'b0, -1);
    send_frame(8'h70, 1'b0, -1);
    chk("after_prefixes", {num1, num2}, 8'h91);
    drained("prefix");

    // bad parity, then a good frame
    send_frame(8'h16, 1'b1, -1);
    chk("after_bad_par", {num1, num2}, 8'h91);
    send_frame(8'h26, 1'b0, -1);
    chk("after_26", {num1, num2}, 8'h13);
    drained("parity");

    // partial frame then timeout
    send_partial(8'h45, 5);
    #(TMO * 10 + 1000);
    chk("timeout_state_idle", state, 2'd0);
    send_frame(8'h45, 1'b0, -1);
    chk("after_timeout_45", {num1, num2}, 8'h30);
    drained("timeout");

    // reset during bit 6 of a frame, then 4, 2, Esc
    send_frame(8'h25, 1'b0, -1);
    send_frame(8'h1E, 1'b0, -1);
    drained("pre_reset");
    send_frame(8'h3D, 1'b0, 6);
    chk("midrst_digits", {num1, num2}, 8'h00);
    chk("midrst_byte", rx_byte, 8'h00);
    chk("midrst_pulses", {key_valid, byte_valid, err}, 3'b000);
    chk("midrst_state", state, 2'd0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    send_frame(8'h25, 1'b0, -1);
    send_frame(8'h1E, 1'b0, -1);
    chk("after_reset_42", {num1, num2}, 8'h42);
    send_frame(8'h76, 1'b0, -1);
    chk("after_esc", {num1, num2}, 8'h00);
    drained("esc");

    // randomized traffic
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1:    b = top_row[$urandom_range(0, 9)];
        2, 3:    b = keypad[$urandom_range(0, 9)];
        4:       b = top_row[$urandom_range(0, 9)];
        5:       b = 8'hF0;
        6:       b = 8'hE0;
        7:       b = 8'h76;
        default: b = 8'($urandom_range(0, 255));
      endcase
      send_frame(b, (r == 9), -1);
    end
    drained("random");
    chk("final_digits", {num1, num2}, {4'(num_model / 10), 4'(num_model % 10)});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
